// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus logic (reader and writer).
package lcd_pkg;

    // Reader state machine states
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EN_HIGH,
        EN_LOW,
        DONE
    } lcd_rd_state_t;

    // RS encodings and the busy-flag bit position on the LCD data bus
    localparam logic RS_INSTR = 1'b0;
    localparam logic RS_DATA  = 1'b1;
    localparam int   BF_BIT   = 7;

    // Largest of three phase lengths, used to size the phase timer
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that times each FSM phase; zero marks the phase's last cycle.
module lcd_phase_timer #(
    parameter int WIDTH = 5
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;

    // Reload on phase entry, otherwise count down and park at zero
    always_ff @(posedge sysclk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/lcd_read_fsm.sv
// LCD bus reader: runs one RW=1 read cycle per request, with optional busy-flag polling.
module lcd_read_fsm
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int EN_HIGH_CYC = 12,
    parameter int EN_LOW_CYC  = 12,
    parameter int MAX_POLLS   = 255
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       readReq,
    input  logic       readRS,
    input  logic       pollBusy,
    input  logic [7:0] lcdDataIn,
    output logic       RSout,
    output logic       RWout,
    output logic       enable,
    output logic       busOwn,
    output logic [7:0] readData,
    output logic       readValid,
    output logic       timeout
);

    localparam int         TW          = $clog2(max3(SETUP_CYC, EN_HIGH_CYC, EN_LOW_CYC)) + 1;
    localparam logic [7:0] MAX_POLLS_B = 8'(MAX_POLLS);

    lcd_rd_state_t state_reg, state_next;
    logic          rs_reg, rs_next;
    logic          poll_reg, poll_next;
    logic [7:0]    poll_cnt_reg, poll_cnt_next;
    logic [7:0]    read_data_reg, read_data_next;
    logic          timer_load;
    logic [TW-1:0] timer_value;
    logic          timer_zero;
    logic          own_next;

    logic          rs_out_reg, rw_reg, enable_reg, bus_own_reg, valid_reg, timeout_reg;

    lcd_phase_timer #(.WIDTH(TW)) u_timer (
        .sysclk     (sysclk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    // Next-state, latched request fields, sample capture and phase timer reloads
    always_comb begin
        state_next     = state_reg;
        rs_next        = rs_reg;
        poll_next      = poll_reg;
        poll_cnt_next  = poll_cnt_reg;
        read_data_next = read_data_reg;
        timer_load     = 1'b0;
        timer_value    = '0;
        case (state_reg)
            IDLE: begin
                if (readReq) begin
                    rs_next       = readRS;
                    // Polling only makes sense on a busy-flag read
                    poll_next     = pollBusy && (readRS == RS_INSTR);
                    poll_cnt_next = 8'd0;
                    state_next    = SETUP;
                    timer_load    = 1'b1;
                    timer_value   = TW'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (timer_zero) begin
                    state_next  = EN_HIGH;
                    timer_load  = 1'b1;
                    timer_value = TW'(EN_HIGH_CYC - 1);
                end
            end
            EN_HIGH: begin
                if (timer_zero) begin
                    read_data_next = lcdDataIn;
                    poll_cnt_next  = (poll_cnt_reg == 8'hFF) ? 8'hFF : poll_cnt_reg + 8'd1;
                    state_next     = EN_LOW;
                    timer_load     = 1'b1;
                    timer_value    = TW'(EN_LOW_CYC - 1);
                end
            end
            EN_LOW: begin
                if (timer_zero) begin
                    if (poll_reg && read_data_reg[BF_BIT] && (poll_cnt_reg < MAX_POLLS_B)) begin
                        state_next  = SETUP;
                        timer_load  = 1'b1;
                        timer_value = TW'(SETUP_CYC - 1);
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign own_next = (state_next == SETUP) || (state_next == EN_HIGH) || (state_next == EN_LOW);

    // State register plus outputs registered from the next state so the LCD pins are glitch-free
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rs_reg        <= 1'b0;
            poll_reg      <= 1'b0;
            poll_cnt_reg  <= 8'd0;
            read_data_reg <= 8'd0;
            rs_out_reg    <= 1'b0;
            rw_reg        <= 1'b0;
            enable_reg    <= 1'b0;
            bus_own_reg   <= 1'b0;
            valid_reg     <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rs_reg        <= rs_next;
            poll_reg      <= poll_next;
            poll_cnt_reg  <= poll_cnt_next;
            read_data_reg <= read_data_next;
            rs_out_reg    <= own_next ? rs_next : 1'b0;
            rw_reg        <= own_next;
            enable_reg    <= (state_next == EN_HIGH);
            bus_own_reg   <= own_next;
            valid_reg     <= (state_next == DONE);
            timeout_reg   <= (state_next == DONE) && poll_reg && read_data_reg[BF_BIT];
        end
    end

    assign RSout     = rs_out_reg;
    assign RWout     = rw_reg;
    assign enable    = enable_reg;
    assign busOwn    = bus_own_reg;
    assign readData  = read_data_reg;
    assign readValid = valid_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_lcd_read_fsm.sv
// Directed testbench for lcd_read_fsm (MAX_POLLS=4, default phase timing).
module tb_lcd_read_fsm;

    logic       sysclk = 1'b0;
    logic       reset = 1'b1;
    logic       readReq = 1'b0;
    logic       readRS = 1'b0;
    logic       pollBusy = 1'b0;
    logic [7:0] lcdDataIn = 8'h00;
    logic       RSout, RWout, enable, busOwn, readValid, timeout;
    logic [7:0] readData;

    int n_checks = 0;
    int n_fail   = 0;
    logic rv_prev = 1'b0;

    lcd_read_fsm #(
        .SETUP_CYC   (2),
        .EN_HIGH_CYC (12),
        .EN_LOW_CYC  (12),
        .MAX_POLLS   (4)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .readReq   (readReq),
        .readRS    (readRS),
        .pollBusy  (pollBusy),
        .lcdDataIn (lcdDataIn),
        .RSout     (RSout),
        .RWout     (RWout),
        .enable    (enable),
        .busOwn    (busOwn),
        .readData  (readData),
        .readValid (readValid),
        .timeout   (timeout)
    );

    always #5 sysclk = ~sysclk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Bus-safety invariants sampled every cycle outside reset
    always @(negedge sysclk) begin
        if (!reset) begin
            check_eq("en_needs_own", 32'(enable && !(busOwn && RWout)), 32'd0);
            check_eq("valid_width", 32'(readValid && rv_prev), 32'd0);
            check_eq("released_after_done", 32'(rv_prev && busOwn), 32'd0);
            rv_prev = readValid;
        end else begin
            rv_prev = 1'b0;
        end
    end

    // One read transaction; data switches from d0 to d1 once more than switch_at pulses started
    task automatic do_read(input logic rs, input logic poll, input logic [7:0] d0, input logic [7:0] d1,
                           input int switch_at, output int lat, output int pulses, output int hi,
                           output logic [3:0] first_pins, output bit got);
        logic en_prev;
        lcdDataIn = d0;
        @(negedge sysclk);
        readReq  = 1'b1;
        readRS   = rs;
        pollBusy = poll;
        @(negedge sysclk);
        readReq  = 1'b0;
        // Flipping the request fields mid-cycle must have no effect
        readRS   = ~rs;
        pollBusy = ~poll;
        first_pins = {busOwn, RWout, RSout, enable};
        lat = 1; pulses = 0; hi = 0; got = 1'b0; en_prev = 1'b0;
        while (lat <= 400) begin
            if (enable) begin
                hi++;
                if (!en_prev) begin
                    pulses++;
                    if (switch_at != 0 && pulses > switch_at) lcdDataIn = d1;
                end
            end
            en_prev = enable;
            if (readValid) begin
                got = 1'b1;
                break;
            end
            @(negedge sysclk);
            lat++;
        end
        if (!got) check_eq("read_timeout_bound", 32'd0, 32'd1);
        $display("read rs=%0b poll=%0b data=%02h timeout=%0b latency=%0d pulses=%0d en_high=%0d",
                 rs, poll, readData, timeout, lat, pulses, hi);
    endtask

    initial begin
        int lat, pulses, hi, valids;
        logic [3:0] pins;
        bit got;

        // Reset state
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        check_eq("rst_RSout", 32'(RSout), 32'd0);
        check_eq("rst_RWout", 32'(RWout), 32'd0);
        check_eq("rst_enable", 32'(enable), 32'd0);
        check_eq("rst_busOwn", 32'(busOwn), 32'd0);
        check_eq("rst_readData", 32'(readData), 32'd0);
        check_eq("rst_readValid", 32'(readValid), 32'd0);
        check_eq("rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;

        // 1. Single data read
        do_read(1'b1, 1'b0, 8'hA5, 8'hA5, 0, lat, pulses, hi, pins, got);
        check_eq("t1_first_pins", 32'(pins), 32'hE);
        check_eq("t1_latency", 32'(lat), 32'd27);
        check_eq("t1_en_high", 32'(hi), 32'd12);
        check_eq("t1_pulses", 32'(pulses), 32'd1);
        check_eq("t1_data", 32'(readData), 32'hA5);
        check_eq("t1_timeout", 32'(timeout), 32'd0);
        check_eq("t1_done_pins", 32'({busOwn, RWout, RSout, enable}), 32'd0);

        // 2. Busy poll clears on the 4th read
        do_read(1'b0, 1'b1, 8'h80, 8'h05, 3, lat, pulses, hi, pins, got);
        check_eq("t2_first_pins", 32'(pins), 32'hC);
        check_eq("t2_pulses", 32'(pulses), 32'd4);
        check_eq("t2_latency", 32'(lat), 32'd105);
        check_eq("t2_data", 32'(readData), 32'h05);
        check_eq("t2_timeout", 32'(timeout), 32'd0);

        // 3. Poll limit reached with BF still set
        do_read(1'b0, 1'b1, 8'h80, 8'h80, 0, lat, pulses, hi, pins, got);
        check_eq("t3_pulses", 32'(pulses), 32'd4);
        check_eq("t3_en_high", 32'(hi), 32'd48);
        check_eq("t3_data", 32'(readData), 32'h80);
        check_eq("t3_timeout", 32'(timeout), 32'd1);

        // pollBusy with readRS=1 is a single read without timeout
        do_read(1'b1, 1'b1, 8'h80, 8'h80, 0, lat, pulses, hi, pins, got);
        check_eq("t3b_pulses", 32'(pulses), 32'd1);
        check_eq("t3b_latency", 32'(lat), 32'd27);
        check_eq("t3b_timeout", 32'(timeout), 32'd0);

        // 4. Reset during EN_HIGH
        lcdDataIn = 8'h11;
        @(negedge sysclk);
        readReq = 1'b1; readRS = 1'b1; pollBusy = 1'b0;
        @(negedge sysclk);
        readReq = 1'b0;
        for (int i = 0; i < 20 && !enable; i++) @(negedge sysclk);
        check_eq("t4_in_en_high", 32'(enable), 32'd1);
        repeat (3) @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        check_eq("t4_enable", 32'(enable), 32'd0);
        check_eq("t4_busOwn", 32'(busOwn), 32'd0);
        check_eq("t4_RWout", 32'(RWout), 32'd0);
        check_eq("t4_readData", 32'(readData), 32'd0);
        reset = 1'b0;
        valids = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sysclk);
            if (readValid) valids++;
        end
        check_eq("t4_no_valid", 32'(valids), 32'd0);
        $display("read aborted by reset, valids=%0d", valids);

        // 5. readReq during EN_LOW and DONE is ignored
        lcdDataIn = 8'h3C;
        valids = 0;
        @(negedge sysclk);
        readReq = 1'b1; readRS = 1'b1; pollBusy = 1'b0;
        @(negedge sysclk);
        readReq = 1'b0;
        for (int i = 0; i < 40 && !enable; i++) @(negedge sysclk);
        for (int i = 0; i < 40 && enable; i++) @(negedge sysclk);
        readReq = 1'b1;
        @(negedge sysclk);
        readReq = 1'b0;
        for (int i = 0; i < 40 && !readValid; i++) @(negedge sysclk);
        check_eq("t5_valid_seen", 32'(readValid), 32'd1);
        valids = 1;
        readReq = 1'b1;
        @(negedge sysclk);
        readReq = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (readValid) valids++;
            @(negedge sysclk);
        end
        check_eq("t5_one_valid", 32'(valids), 32'd1);
        check_eq("t5_data", 32'(readData), 32'h3C);
        check_eq("t5_idle_busOwn", 32'(busOwn), 32'd0);
        $display("read with ignored requests, valids=%0d data=%02h", valids, readData);

        // Back-to-back requests in IDLE
        do_read(1'b1, 1'b0, 8'h5A, 8'h5A, 0, lat, pulses, hi, pins, got);
        check_eq("t5_b2b_first", 32'(readData), 32'h5A);
        do_read(1'b1, 1'b0, 8'hC3, 8'hC3, 0, lat, pulses, hi, pins, got);
        check_eq("t5_b2b_pins", 32'(pins), 32'hE);
        check_eq("t5_b2b_latency", 32'(lat), 32'd27);
        check_eq("t5_b2b_data", 32'(readData), 32'hC3);

        repeat (3) @(negedge sysclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
